div_unit: RTL and testbench

- Iterative RV32M divider for the integer core. It implements DIV, DIVU, REM and REMU.
- It consumes the two register-file read operands and the destination index from decode/execute.
- It produces a register-file write port (wen/waddr/wdata), which the writeback arbiter routes into the integer register file.
- It is a multi-cycle unit with a start/busy handshake, a held result on writeback backpressure, and pipeline-flush abort.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit_if.sv | 30 +++
 rtl/div_unit.sv | 134 +++++++++++++
 tb/tb_div_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared core definitions for the RV32M divider: widths and div_op encodings.
package div_unit_pkg;

  localparam int unsigned RV_CPU_WIDTH      = 32;
  localparam int unsigned RV_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/writeback bundle between decode/execute, the divider and the writeback arbiter.
interface div_unit_if
  import div_unit_pkg::*;
#(
  parameter int unsigned CPU_WIDTH      = RV_CPU_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
);
  logic                      div_start;
  logic                      div_ready;
  logic [1:0]                div_op;
  logic [REG_ADDR_WIDTH-1:0] div_rd;
  logic [CPU_WIDTH-1:0]      div_rs1_data;
  logic [CPU_WIDTH-1:0]      div_rs2_data;
  logic                      flush;
  logic                      wb_ready;
  logic                      div_busy;
  logic                      reg_wen;
  logic [REG_ADDR_WIDTH-1:0] reg_waddr;
  logic [CPU_WIDTH-1:0]      reg_wdata;

  modport master (
    output div_start, div_op, div_rd, div_rs1_data, div_rs2_data, flush, wb_ready,
    input  div_ready, div_busy, reg_wen, reg_waddr, reg_wdata
  );

  modport slave (
    input  div_start, div_op, div_rd, div_rs1_data, div_rs2_data, flush, wb_ready,
    output div_ready, div_busy, reg_wen, reg_waddr, reg_wdata
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU with start/busy
// handshake, writeback backpressure hold and flush abort.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned CPU_WIDTH      = RV_CPU_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = RV_REG_ADDR_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  div_unit_if.slave div_if
);

  localparam int unsigned CNT_W = $clog2(CPU_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(CPU_WIDTH - 1);
  localparam logic [CPU_WIDTH-1:0] MIN_NEG  = {1'b1, {(CPU_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  div_op_e                   op_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0]          count_q;
  logic [CPU_WIDTH-1:0]      quo_q, rem_q, dvsr_q, result_q;

  logic                      accept, special, last_iter;
  logic                      signed_op, sign1, sign2;
  logic [CPU_WIDTH-1:0]      abs1, abs2, special_res;
  logic [2*CPU_WIDTH:0]      iter;
  logic [CPU_WIDTH-1:0]      next_quo, next_rem, quo_fix, rem_fix;
  div_op_e                   req_op;

  // The partial remainder always stays below the divisor, so only the trial
  // difference needs the extra bit to keep the compare unsigned.
  function automatic logic [2*CPU_WIDTH:0] div_iter(
    input logic [CPU_WIDTH-1:0] rem,
    input logic [CPU_WIDTH-1:0] quo,
    input logic [CPU_WIDTH-1:0] dvsr
  );
    logic [CPU_WIDTH:0] shifted;
    logic [CPU_WIDTH:0] diff;
    shifted = {rem, quo[CPU_WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (shifted >= {1'b0, dvsr}) begin
      return {diff, quo[CPU_WIDTH-2:0], 1'b1};
    end
    return {shifted, quo[CPU_WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    req_op    = div_op_e'(div_if.div_op);
    accept    = (state_q == S_IDLE) && div_if.div_start && !div_if.flush;
    signed_op = !req_op[0];
    sign1     = signed_op && div_if.div_rs1_data[CPU_WIDTH-1];
    sign2     = signed_op && div_if.div_rs2_data[CPU_WIDTH-1];
    abs1      = sign1 ? -div_if.div_rs1_data : div_if.div_rs1_data;
    abs2      = sign2 ? -div_if.div_rs2_data : div_if.div_rs2_data;

    special     = 1'b0;
    special_res = '0;
    if (div_if.div_rs2_data == '0) begin
      special     = 1'b1;
      special_res = req_op[1] ? div_if.div_rs1_data : '1;
    end else if (signed_op && div_if.div_rs1_data == MIN_NEG && div_if.div_rs2_data == '1) begin
      special     = 1'b1;
      special_res = req_op[1] ? '0 : MIN_NEG;
    end

    iter      = div_iter(rem_q, quo_q, dvsr_q);
    next_rem  = iter[2*CPU_WIDTH-1:CPU_WIDTH];
    next_quo  = iter[CPU_WIDTH-1:0];
    quo_fix   = (op_q == DIV_OP_DIV && neg_quo_q) ? -next_quo : next_quo;
    rem_fix   = (op_q == DIV_OP_REM && neg_rem_q) ? -next_rem : next_rem;
    last_iter = (count_q == LAST_CNT);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (last_iter) state_d = S_DONE;
      S_DONE: if (div_if.wb_ready || rd_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (div_if.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= DIV_OP_DIV;
      rd_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= req_op;
      rd_q      <= div_if.div_rd;
      neg_quo_q <= sign1 ^ sign2;
      neg_rem_q <= sign1;
      count_q   <= '0;
      quo_q     <= abs1;
      rem_q     <= '0;
      dvsr_q    <= abs2;
      result_q  <= special_res;
    end else if (state_q == S_CALC) begin
      quo_q   <= next_quo;
      rem_q   <= next_rem;
      count_q <= count_q + 1'b1;
      if (last_iter) result_q <= op_q[1] ? rem_fix : quo_fix;
    end
  end

  // Write port is decoded from registered state only.
  assign div_if.div_ready = (state_q == S_IDLE);
  assign div_if.div_busy  = (state_q != S_IDLE);
  assign div_if.reg_wen   = (state_q == S_DONE) && (rd_q != '0);
  assign div_if.reg_waddr = (state_q == S_DONE) ? rd_q : '0;
  assign div_if.reg_wdata = (state_q == S_DONE) ? result_q : '0;

endmodule

// File: tb/tb_div_unit.sv
// Directed, table-driven check of div_unit: results, latency, backpressure,
// flush/reset abort and rd==0 handling.
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dif ();

  div_unit #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (dif)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  always @(posedge clk) begin
    if (dif.reg_wen && dif.wb_ready) wr_count++;
  end

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    dif.div_op       = op;
    dif.div_rd       = rd;
    dif.div_rs1_data = a;
    dif.div_rs2_data = b;
    dif.div_start    = 1'b1;
    @(negedge clk);
    dif.div_start    = 1'b0;
  endtask

  task automatic wait_wen(output int lat);
    lat = 0;
    while (!dif.reg_wen && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int lat;
  int w0;

  initial begin
    vecs[0]  = '{DIV_OP_DIVU, 5'd5, 32'd100,        32'd7,          32'd14,         32};
    vecs[1]  = '{DIV_OP_REMU, 5'd5, 32'd100,        32'd7,          32'd2,          32};
    vecs[2]  = '{DIV_OP_DIV,  5'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32};
    vecs[3]  = '{DIV_OP_REM,  5'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32};
    vecs[4]  = '{DIV_OP_REM,  5'd4, 32'd7,          32'hFFFF_FFFE,  32'd1,          32};
    vecs[5]  = '{DIV_OP_DIV,  5'd4, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32};
    vecs[6]  = '{DIV_OP_DIV,  5'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32};
    vecs[7]  = '{DIV_OP_REM,  5'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32};
    vecs[8]  = '{DIV_OP_DIVU, 5'd8, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  0};
    vecs[9]  = '{DIV_OP_REM,  5'd8, 32'h0000_1234,  32'd0,          32'h0000_1234,  0};
    vecs[10] = '{DIV_OP_DIV,  5'd9, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[11] = '{DIV_OP_REM,  5'd9, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[12] = '{DIV_OP_DIVU, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          32};
    vecs[13] = '{DIV_OP_REMU, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32};
    vecs[14] = '{DIV_OP_DIV,  5'd11, 32'h8000_0000, 32'd2,          32'hC000_0000,  32};
    vecs[15] = '{DIV_OP_DIVU, 5'd31, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  32};
    vecs[16] = '{DIV_OP_REMU, 5'd12, 32'd5,         32'h10,         32'd5,          32};
    vecs[17] = '{DIV_OP_DIV,  5'd12, 32'hFFFF_FFFF, 32'd0,          32'hFFFF_FFFF,  0};

    dif.div_start = 1'b0; dif.div_op = 2'b00; dif.div_rd = '0;
    dif.div_rs1_data = '0; dif.div_rs2_data = '0;
    dif.flush = 1'b0; dif.wb_ready = 1'b1;

    idle_cycles(3);
    rst_n = 1'b1;
    check("reset ready", {31'd0, dif.div_ready}, 32'd1);
    check("reset busy",  {31'd0, dif.div_busy},  32'd0);
    check("reset wen",   {31'd0, dif.reg_wen},   32'd0);
    check("reset waddr", {27'd0, dif.reg_waddr}, 32'd0);
    check("reset wdata", dif.reg_wdata,          32'd0);

    for (int i = 0; i < NV; i++) begin
      w0 = wr_count;
      issue(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].b);
      wait_wen(lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d wdata", i), dif.reg_wdata, vecs[i].exp);
      check($sformatf("v%0d waddr", i), {27'd0, dif.reg_waddr}, {27'd0, vecs[i].rd});
      @(negedge clk);
      check($sformatf("v%0d wen drop", i), {31'd0, dif.reg_wen}, 32'd0);
      check($sformatf("v%0d ready after", i), {31'd0, dif.div_ready}, 32'd1);
      check($sformatf("v%0d writes", i), wr_count, w0 + 1);
    end

    // Backpressure hold with ignored start pulses while busy.
    w0 = wr_count;
    dif.wb_ready = 1'b0;
    issue(DIV_OP_DIVU, 5'd7, 32'd100, 32'd7);
    idle_cycles(4);
    check("bp busy ready", {31'd0, dif.div_ready}, 32'd0);
    issue(DIV_OP_DIVU, 5'd2, 32'd50, 32'd5);
    wait_wen(lat);
    check("bp latency", lat, 27);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold wen %0d", i),   {31'd0, dif.reg_wen},   32'd1);
      check($sformatf("bp hold waddr %0d", i), {27'd0, dif.reg_waddr}, 32'd7);
      check($sformatf("bp hold wdata %0d", i), dif.reg_wdata,          32'd14);
      if (i == 2) issue(DIV_OP_DIVU, 5'd2, 32'd50, 32'd5);
      else @(negedge clk);
    end
    dif.wb_ready = 1'b1;
    @(negedge clk);
    check("bp released wen", {31'd0, dif.reg_wen}, 32'd0);
    check("bp released ready", {31'd0, dif.div_ready}, 32'd1);
    idle_cycles(40);
    check("bp single write", wr_count, w0 + 1);

    // Flush at count 10.
    w0 = wr_count;
    issue(DIV_OP_DIVU, 5'd5, 32'd100, 32'd7);
    idle_cycles(10);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush ready", {31'd0, dif.div_ready}, 32'd1);
    check("flush busy",  {31'd0, dif.div_busy},  32'd0);
    idle_cycles(40);
    check("flush no write", wr_count, w0);

    // Reset mid-CALC.
    w0 = wr_count;
    issue(DIV_OP_DIV, 5'd13, 32'hFFFF_FFF9, 32'd2);
    idle_cycles(5);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst ready", {31'd0, dif.div_ready}, 32'd1);
    check("rst busy",  {31'd0, dif.div_busy},  32'd0);
    check("rst wen",   {31'd0, dif.reg_wen},   32'd0);
    check("rst waddr", {27'd0, dif.reg_waddr}, 32'd0);
    check("rst wdata", dif.reg_wdata,          32'd0);
    rst_n = 1'b1;
    idle_cycles(40);
    check("rst no write", wr_count, w0);

    // Flush together with start from IDLE.
    w0 = wr_count;
    dif.flush = 1'b1;
    issue(DIV_OP_DIVU, 5'd5, 32'd100, 32'd7);
    dif.flush = 1'b0;
    check("flush+start ready", {31'd0, dif.div_ready}, 32'd1);
    idle_cycles(40);
    check("flush+start no write", wr_count, w0);

    // rd==0 passes through DONE without a write, then back-to-back rd=1.
    w0 = wr_count;
    issue(DIV_OP_DIVU, 5'd0, 32'd9, 32'd3);
    idle_cycles(32);
    check("rd0 in done busy", {31'd0, dif.div_busy}, 32'd1);
    check("rd0 wen",          {31'd0, dif.reg_wen},  32'd0);
    @(negedge clk);
    check("rd0 ready", {31'd0, dif.div_ready}, 32'd1);
    check("rd0 no write", wr_count, w0);
    issue(DIV_OP_DIVU, 5'd1, 32'd9, 32'd3);
    wait_wen(lat);
    check("rd1 latency", lat, 32);
    check("rd1 wdata", dif.reg_wdata, 32'd3);
    check("rd1 waddr", {27'd0, dif.reg_waddr}, 32'd1);
    @(negedge clk);
    check("rd1 writes", wr_count, w0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
